// File: rtl/bow_draw_if.sv
// Bow overlay controller bus: fire/zoom/arrow-busy inputs and
// the registered overlay code, shot pulse and power outputs.
interface bow_draw_if;
    logic       frame_tick;
    logic       fire_btn;
    logic       zoom_btn;
    logic       arrow_busy;
    logic [3:0] bow_state;
    logic       fire_pulse;
    logic [2:0] fire_power;
    logic       drawing;

    modport master (
        output frame_tick,
        output fire_btn,
        output zoom_btn,
        output arrow_busy,
        input  bow_state,
        input  fire_pulse,
        input  fire_power,
        input  drawing
    );

    modport slave (
        input  frame_tick,
        input  fire_btn,
        input  zoom_btn,
        input  arrow_busy,
        output bow_state,
        output fire_pulse,
        output fire_power,
        output drawing
    );
endinterface

// File: rtl/bow_draw_controller.sv
// Bow draw sequencer: fire button -> overlay code, frame-tick paced
// draw frames, one-cycle fire pulse with power, then cooldown.
module bow_draw_controller #(
    parameter int unsigned FRAMES_PER_STEP = 6,
    parameter int unsigned COOLDOWN_TICKS  = 30
) (
    input  logic     Clk,
    input  logic     Reset,
    bow_draw_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_FULL,
        S_RELEASE,
        S_COOLDOWN
    } state_e;

    localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [7:0] CD_LAST   = 8'(COOLDOWN_TICKS - 1);

    state_e     state_q, state_d;
    logic [2:0] frame_idx_q, frame_idx_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic       fire_btn_q;
    logic [3:0] bow_state_q, bow_state_d;
    logic       fire_pulse_q, fire_pulse_d;
    logic [2:0] fire_power_q, fire_power_d;
    logic       drawing_q, drawing_d;
    logic       press;

    assign press = bus.fire_btn & ~fire_btn_q;

    always_comb begin
        state_d      = state_q;
        frame_idx_d  = frame_idx_q;
        tick_cnt_d   = tick_cnt_q;
        fire_power_d = fire_power_q;
        unique case (state_q)
            S_IDLE: begin
                if (press && !bus.arrow_busy) begin
                    state_d     = S_DRAW;
                    frame_idx_d = 3'd1;
                    tick_cnt_d  = 8'd0;
                end
            end
            S_DRAW: begin
                // Release outranks a coincident frame advance
                if (!bus.fire_btn) begin
                    state_d      = S_RELEASE;
                    fire_power_d = frame_idx_q;
                end else if (bus.frame_tick) begin
                    if (tick_cnt_q == STEP_LAST) begin
                        tick_cnt_d  = 8'd0;
                        frame_idx_d = frame_idx_q + 3'd1;
                        if (frame_idx_q == 3'd4) begin
                            state_d = S_FULL;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
            end
            S_FULL: begin
                if (!bus.fire_btn) begin
                    state_d      = S_RELEASE;
                    fire_power_d = frame_idx_q;
                end
            end
            S_RELEASE: begin
                state_d     = S_COOLDOWN;
                tick_cnt_d  = 8'd0;
                frame_idx_d = 3'd0;
            end
            S_COOLDOWN: begin
                if (bus.frame_tick) begin
                    if (tick_cnt_q == CD_LAST) begin
                        state_d    = S_IDLE;
                        tick_cnt_d = 8'd0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                frame_idx_d = 3'd0;
                tick_cnt_d  = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it
    always_comb begin
        bow_state_d  = 4'd7;
        fire_pulse_d = (state_d == S_RELEASE);
        drawing_d    = (state_d == S_DRAW) || (state_d == S_FULL);
        unique case (state_d)
            S_IDLE:  bow_state_d = bus.zoom_btn ? 4'd6 : 4'd7;
            S_DRAW:  bow_state_d = {1'b0, frame_idx_d};
            S_FULL:  bow_state_d = 4'd5;
            default: bow_state_d = 4'd0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            frame_idx_q  <= 3'd0;
            tick_cnt_q   <= 8'd0;
            fire_btn_q   <= 1'b0;
            bow_state_q  <= 4'd7;
            fire_pulse_q <= 1'b0;
            fire_power_q <= 3'd0;
            drawing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_idx_q  <= frame_idx_d;
            tick_cnt_q   <= tick_cnt_d;
            fire_btn_q   <= bus.fire_btn;
            bow_state_q  <= bow_state_d;
            fire_pulse_q <= fire_pulse_d;
            fire_power_q <= fire_power_d;
            drawing_q    <= drawing_d;
        end
    end

    assign bus.bow_state  = bow_state_q;
    assign bus.fire_pulse = fire_pulse_q;
    assign bus.fire_power = fire_power_q;
    assign bus.drawing    = drawing_q;

endmodule

// File: tb/tb_bow_draw_controller.sv
// Directed bench for bow_draw_controller with FRAMES_PER_STEP=2,
// COOLDOWN_TICKS=3.
module tb_bow_draw_controller;

    logic clk;
    logic rst;
    int   vec;
    int   err;

    bow_draw_if bif ();

    bow_draw_controller #(
        .FRAMES_PER_STEP(2),
        .COOLDOWN_TICKS (3)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bif.frame_tick = 1'b1;
        cyc();
        bif.frame_tick = 1'b0;
    endtask

    task automatic drain_cooldown();
        cyc();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.zoom_btn = 1'b0;
        cyc();
        vec++;
        if (bif.bow_state !== 4'd7) begin
            err++;
            $display("FAIL reset_bow got %0d exp 7", bif.bow_state);
        end
        vec++;
        if ({bif.fire_pulse, bif.fire_power, bif.drawing} !== 5'd0) begin
            err++;
            $display("FAIL reset_outs got %b exp 00000",
                     {bif.fire_pulse, bif.fire_power, bif.drawing});
        end
        rst = 1'b0;
        cyc();
        bif.zoom_btn = 1'b1;
        cyc();
        vec++;
        if (bif.bow_state !== 4'd6) begin
            err++;
            $display("FAIL zoom_idle got %0d exp 6", bif.bow_state);
        end
        bif.zoom_btn = 1'b0;
        cyc();
        vec++;
        if (bif.bow_state !== 4'd7) begin
            err++;
            $display("FAIL unzoom_idle got %0d exp 7", bif.bow_state);
        end
    endtask

    task automatic test_full_draw();
        bif.fire_btn = 1'b1;
        cyc();
        vec++;
        if (bif.bow_state !== 4'd1 || bif.drawing !== 1'b1) begin
            err++;
            $display("FAIL press bow %0d drw %b exp 1 1",
                     bif.bow_state, bif.drawing);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            vec++;
            if (bif.bow_state !== 4'(1 + k / 2)) begin
                err++;
                $display("FAIL draw_tick%0d got %0d exp %0d",
                         k, bif.bow_state, 1 + k / 2);
            end
        end
        tick();
        tick();
        bif.zoom_btn = 1'b1;
        cyc();
        vec++;
        if (bif.bow_state !== 4'd5 || bif.drawing !== 1'b1) begin
            err++;
            $display("FAIL full_hold bow %0d drw %b exp 5 1",
                     bif.bow_state, bif.drawing);
        end
        bif.zoom_btn = 1'b0;
        bif.fire_btn = 1'b0;
        cyc();
        vec++;
        if ({bif.bow_state, bif.fire_pulse, bif.fire_power, bif.drawing}
            !== {4'd0, 1'b1, 3'd5, 1'b0}) begin
            err++;
            $display("FAIL full_release bow %0d pls %b pwr %0d exp 0 1 5",
                     bif.bow_state, bif.fire_pulse, bif.fire_power);
        end
        drain_cooldown();
        vec++;
        if (bif.bow_state !== 4'd7) begin
            err++;
            $display("FAIL full_cd_end got %0d exp 7", bif.bow_state);
        end
    endtask

    task automatic test_release_power();
        bif.fire_btn = 1'b1;
        cyc();
        tick();
        tick();
        tick();
        vec++;
        if (bif.bow_state !== 4'd2) begin
            err++;
            $display("FAIL rel_pre got %0d exp 2", bif.bow_state);
        end
        bif.fire_btn = 1'b0;
        cyc();
        vec++;
        if ({bif.bow_state, bif.fire_pulse, bif.fire_power, bif.drawing}
            !== {4'd0, 1'b1, 3'd2, 1'b0}) begin
            err++;
            $display("FAIL rel_pulse bow %0d pls %b pwr %0d drw %b exp 0 1 2 0",
                     bif.bow_state, bif.fire_pulse, bif.fire_power,
                     bif.drawing);
        end
        cyc();
        vec++;
        if (bif.fire_pulse !== 1'b0 || bif.fire_power !== 3'd2) begin
            err++;
            $display("FAIL rel_one_shot pls %b pwr %0d exp 0 2",
                     bif.fire_pulse, bif.fire_power);
        end
        tick();
        tick();
        vec++;
        if (bif.bow_state !== 4'd0) begin
            err++;
            $display("FAIL cd_mid got %0d exp 0", bif.bow_state);
        end
        tick();
        vec++;
        if (bif.bow_state !== 4'd7) begin
            err++;
            $display("FAIL cd_end got %0d exp 7", bif.bow_state);
        end
    endtask

    task automatic test_blocked();
        bif.fire_btn = 1'b1;
        cyc();
        bif.fire_btn = 1'b0;
        cyc();
        cyc();
        bif.fire_btn = 1'b1;
        cyc();
        vec++;
        if (bif.bow_state !== 4'd0 || bif.drawing !== 1'b0) begin
            err++;
            $display("FAIL cd_press bow %0d drw %b exp 0 0",
                     bif.bow_state, bif.drawing);
        end
        tick();
        tick();
        tick();
        cyc();
        cyc();
        vec++;
        if (bif.bow_state !== 4'd7 || bif.drawing !== 1'b0) begin
            err++;
            $display("FAIL held_after_cd bow %0d drw %b exp 7 0",
                     bif.bow_state, bif.drawing);
        end
        bif.fire_btn = 1'b0;
        cyc();
        bif.arrow_busy = 1'b1;
        bif.fire_btn = 1'b1;
        cyc();
        vec++;
        if (bif.bow_state !== 4'd7 || bif.drawing !== 1'b0) begin
            err++;
            $display("FAIL busy_press bow %0d drw %b exp 7 0",
                     bif.bow_state, bif.drawing);
        end
        bif.arrow_busy = 1'b0;
        cyc();
        cyc();
        vec++;
        if (bif.bow_state !== 4'd7) begin
            err++;
            $display("FAIL busy_drop_held got %0d exp 7", bif.bow_state);
        end
        bif.fire_btn = 1'b0;
        cyc();
        bif.fire_btn = 1'b1;
        cyc();
        vec++;
        if (bif.bow_state !== 4'd1 || bif.drawing !== 1'b1) begin
            err++;
            $display("FAIL fresh_press bow %0d drw %b exp 1 1",
                     bif.bow_state, bif.drawing);
        end
        bif.fire_btn = 1'b0;
        cyc();
        vec++;
        if (bif.fire_pulse !== 1'b1 || bif.fire_power !== 3'd1) begin
            err++;
            $display("FAIL quick_rel pls %b pwr %0d exp 1 1",
                     bif.fire_pulse, bif.fire_power);
        end
        drain_cooldown();
    endtask

    task automatic test_coincident();
        bif.fire_btn = 1'b1;
        bif.frame_tick = 1'b1;
        cyc();
        bif.frame_tick = 1'b0;
        tick();
        vec++;
        if (bif.bow_state !== 4'd1) begin
            err++;
            $display("FAIL press_tick got %0d exp 1", bif.bow_state);
        end
        tick();
        tick();
        tick();
        tick();
        vec++;
        if (bif.bow_state !== 4'd3) begin
            err++;
            $display("FAIL at_frame3 got %0d exp 3", bif.bow_state);
        end
        bif.fire_btn = 1'b0;
        bif.frame_tick = 1'b1;
        cyc();
        bif.frame_tick = 1'b0;
        vec++;
        if ({bif.bow_state, bif.fire_pulse, bif.fire_power}
            !== {4'd0, 1'b1, 3'd3}) begin
            err++;
            $display("FAIL rel_vs_tick bow %0d pls %b pwr %0d exp 0 1 3",
                     bif.bow_state, bif.fire_pulse, bif.fire_power);
        end
        drain_cooldown();
    endtask

    task automatic test_reset_mid();
        bif.fire_btn = 1'b1;
        cyc();
        for (int k = 0; k < 8; k++) tick();
        vec++;
        if (bif.bow_state !== 4'd5) begin
            err++;
            $display("FAIL pre_rst_full got %0d exp 5", bif.bow_state);
        end
        rst = 1'b1;
        cyc();
        vec++;
        if ({bif.bow_state, bif.fire_pulse, bif.fire_power, bif.drawing}
            !== {4'd7, 1'b0, 3'd0, 1'b0}) begin
            err++;
            $display("FAIL rst_full bow %0d pls %b pwr %0d drw %b exp 7 0 0 0",
                     bif.bow_state, bif.fire_pulse, bif.fire_power,
                     bif.drawing);
        end
        rst = 1'b0;
        cyc();
        vec++;
        if (bif.bow_state !== 4'd1 || bif.drawing !== 1'b1) begin
            err++;
            $display("FAIL post_rst_edge bow %0d drw %b exp 1 1",
                     bif.bow_state, bif.drawing);
        end
        bif.fire_btn = 1'b0;
        cyc();
        vec++;
        if (bif.fire_pulse !== 1'b1 || bif.fire_power !== 3'd1) begin
            err++;
            $display("FAIL pre_rst_rel pls %b pwr %0d exp 1 1",
                     bif.fire_pulse, bif.fire_power);
        end
        rst = 1'b1;
        cyc();
        vec++;
        if ({bif.bow_state, bif.fire_pulse, bif.fire_power, bif.drawing}
            !== {4'd7, 1'b0, 3'd0, 1'b0}) begin
            err++;
            $display("FAIL rst_release bow %0d pls %b pwr %0d drw %b exp 7 0 0 0",
                     bif.bow_state, bif.fire_pulse, bif.fire_power,
                     bif.drawing);
        end
        rst = 1'b0;
        cyc();
        vec++;
        if (bif.bow_state !== 4'd7 || bif.fire_pulse !== 1'b0) begin
            err++;
            $display("FAIL rst_release_idle bow %0d pls %b exp 7 0",
                     bif.bow_state, bif.fire_pulse);
        end
    endtask

    initial begin
        vec = 0;
        err = 0;
        rst = 1'b1;
        bif.frame_tick = 1'b0;
        bif.fire_btn   = 1'b0;
        bif.zoom_btn   = 1'b0;
        bif.arrow_busy = 1'b0;
        test_reset();
        test_full_draw();
        test_release_power();
        test_blocked();
        test_coincident();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
